// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM controller: opcodes, FSM states and
// the opcode selection helper.
package spi_ram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int         CMD_BITS  = 32;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  function automatic logic [7:0] cmd_byte(input logic we);
    return we ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register: MSB leaves first on serial_out, serial_in
// enters at the LSB. The low TAP_WIDTH bits are exposed for receive capture.
module spi_shift_reg #(
  parameter int WIDTH     = 48,
  parameter int TAP_WIDTH = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_data,
  input  logic                 shift,
  input  logic                 serial_in,
  output logic                 serial_out,
  output logic [TAP_WIDTH-1:0] tap
);

  logic [WIDTH-1:0] data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {data[WIDTH-2:0], serial_in};
    end
  end

  assign serial_out = data[WIDTH-1];
  assign tap        = data[TAP_WIDTH-1:0];

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI RAM controller (mode 0): one read (03h) or write (02h) of DATA_BYTES
// bytes per request, 24-bit address, two clk cycles per SPI bit.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [23:0]             addr,
  input  logic [8*DATA_BYTES-1:0] wdata,
  output logic                    ready,
  output logic                    done,
  output logic [8*DATA_BYTES-1:0] rdata,
  output logic                    spi_clk,
  output logic                    spi_mosi,
  output logic                    spi_select,
  input  logic                    spi_miso
);

  localparam int         DW            = 8 * DATA_BYTES;
  localparam int         TOTAL_BITS    = CMD_BITS + DW;
  localparam logic [5:0] LAST_CMD_BIT  = 6'(CMD_BITS - 1);
  localparam logic [5:0] LAST_BIT      = 6'(TOTAL_BITS - 1);

  state_t        state, state_next;
  logic          phase, phase_next;
  logic [5:0]    bit_cnt, bit_cnt_next;
  logic          we_r;
  logic [DW-1:0] rdata_r;

  logic          sr_load, sr_shift, sr_in, sr_out;
  logic [DW-2:0] sr_tap;
  logic [DW-1:0] wdata_wire;
  logic [DW-1:0] rx_word;
  logic [DW-1:0] rx_value;
  logic          last_read_bit;

  // The wire carries byte 0 first, so bytes are swapped into MSB-first order
  // before loading, and swapped back when a read completes.
  always_comb begin
    wdata_wire = '0;
    rx_value   = '0;
    rx_word    = {sr_tap, sr_in};
    for (int k = 0; k < DATA_BYTES; k++) begin
      wdata_wire[DW-1-8*k -: 8] = wdata[8*k +: 8];
      rx_value[8*k +: 8]        = rx_word[DW-1-8*k -: 8];
    end
  end

  assign sr_load  = (state == IDLE) && req;
  assign sr_shift = ((state == CMD) || (state == DATA)) && phase;
  assign sr_in    = (state == DATA) && !we_r && spi_miso;

  spi_shift_reg #(
    .WIDTH     (TOTAL_BITS),
    .TAP_WIDTH (DW - 1)
  ) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (sr_load),
    .load_data  ({cmd_byte(we), addr, wdata_wire}),
    .shift      (sr_shift),
    .serial_in  (sr_in),
    .serial_out (sr_out),
    .tap        (sr_tap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      phase   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    phase_next   = phase;
    bit_cnt_next = bit_cnt;
    ready        = 1'b0;
    done         = 1'b0;
    spi_clk      = 1'b0;
    spi_select   = 1'b1;
    spi_mosi     = 1'b0;
    case (state)
      IDLE: begin
        ready        = 1'b1;
        phase_next   = 1'b0;
        bit_cnt_next = '0;
        if (req) state_next = CMD;
      end
      CMD, DATA: begin
        spi_select = 1'b0;
        spi_clk    = phase;
        spi_mosi   = (state == CMD || we_r) ? sr_out : 1'b0;
        phase_next = ~phase;
        if (phase) begin
          bit_cnt_next = bit_cnt + 6'd1;
          if (state == CMD && bit_cnt == LAST_CMD_BIT) state_next = DATA;
          if (state == DATA && bit_cnt == LAST_BIT)    state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        state_next   = IDLE;
        phase_next   = 1'b0;
        bit_cnt_next = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final MISO bit is folded in on the same edge that enters DONE so
  // rdata is already valid while done is high.
  assign last_read_bit = (state == DATA) && phase && (bit_cnt == LAST_BIT) && !we_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      rdata_r <= '0;
    end else begin
      if (sr_load)       we_r    <= we;
      if (last_read_bit) rdata_r <= rx_value;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl (DATA_BYTES=2) with a small
// behavioural SPI RAM model attached to the serial pins.
`timescale 1ns/1ps
module tb_spi_ram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [23:0] addr;
  logic [15:0] wdata;
  logic        ready;
  logic        done;
  logic [15:0] rdata;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_select;
  logic        spi_miso;

  int compared;
  int mismatched;

  spi_ram_ctrl #(.DATA_BYTES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .done       (done),
    .rdata      (rdata),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_select (spi_select),
    .spi_miso   (spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI RAM model: 256 bytes, decodes 03h/02h, drives MISO after each falling
  // SPI edge and holds it high whenever it is not returning read data.
  logic [7:0]  mem [0:255];
  logic [7:0]  mosi_log [$];
  int          bitn;
  logic [31:0] hdr;
  logic [7:0]  cur;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h34;
    mem[8'h21] = 8'h12;
    spi_miso = 1'b1;
    bitn = 0;
    hdr = '0;
    cur = '0;
  end

  always @(negedge spi_select) begin
    bitn = 0;
    hdr  = '0;
    cur  = '0;
    mosi_log.delete();
    spi_miso = 1'b1;
  end

  always @(posedge spi_clk) begin
    logic [7:0] a;
    if (!spi_select) begin
      cur = {cur[6:0], spi_mosi};
      if (bitn < 32) hdr = {hdr[30:0], spi_mosi};
      bitn++;
      if (bitn % 8 == 0) begin
        mosi_log.push_back(cur);
        if (bitn > 32 && hdr[31:24] == 8'h02) begin
          a = hdr[7:0] + 8'((bitn - 40) / 8);
          mem[a] = cur;
        end
      end
    end
  end

  always @(negedge spi_clk) begin
    logic [7:0] a;
    if (!spi_select && bitn >= 32 && hdr[31:24] == 8'h03) begin
      a = hdr[7:0] + 8'((bitn - 32) / 8);
      spi_miso = mem[a][7 - ((bitn - 32) % 8)];
    end else begin
      spi_miso = 1'b1;
    end
  end

  function automatic logic [63:0] log_word();
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < mosi_log.size() && i < 8; i++) w = {w[55:0], mosi_log[i]};
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // One transaction from an idle, ready DUT; returns one cycle after done.
  task automatic applyStimulus(input logic w, input logic [23:0] a, input logic [15:0] d,
                               input bit toggle_req, input string tag);
    int done_cyc, sel_low, clk_bad, ready_bad;
    done_cyc = 0; sel_low = 0; clk_bad = 0; ready_bad = 0;
    checkOutput({tag, "_ready_in"}, ready, 1);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        done_cyc = k + 1;
        break;
      end
      if (!spi_select) sel_low++;
      if (spi_clk !== k[0]) clk_bad++;
      if (ready) ready_bad++;
      req = (toggle_req && k < 80) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    req = 1'b0;
    checkOutput({tag, "_done_cycle"}, done_cyc, 97);
    checkOutput({tag, "_select_low"}, sel_low, 96);
    checkOutput({tag, "_spi_clk"}, clk_bad, 0);
    checkOutput({tag, "_ready_busy"}, ready_bad, 0);
    checkOutput({tag, "_done_pins"}, {spi_select, spi_clk, spi_mosi, ready}, 4'b1000);
    @(posedge clk); #1;
    checkOutput({tag, "_ready_after"}, {ready, done, spi_select}, 3'b101);
  endtask

  initial begin
    int cyc;
    int dcount;
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_pins", {spi_select, spi_clk, spi_mosi, done}, 4'b1000);
    checkOutput("reset_rdata", rdata, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_ready", ready, 1);

    applyStimulus(1'b1, 24'h000010, 16'hBEEF, 1'b0, "wr10");
    checkOutput("wr10_mosi", log_word(), 64'h0000_0200_0010_EFBE);
    checkOutput("wr10_mem", {mem[8'h10], mem[8'h11]}, 16'hEFBE);
    checkOutput("wr10_rdata_kept", rdata, 16'h0000);

    applyStimulus(1'b0, 24'h000010, 16'h0000, 1'b0, "rd10");
    checkOutput("rd10_mosi", log_word(), 64'h0000_0300_0010_0000);
    checkOutput("rd10_rdata", rdata, 16'hBEEF);

    applyStimulus(1'b0, 24'h000020, 16'hFFFF, 1'b1, "rd20");
    checkOutput("rd20_rdata", rdata, 16'h1234);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_extra_txn", {spi_select, ready}, 2'b11);

    applyStimulus(1'b1, 24'h000030, 16'h5678, 1'b1, "wr30");
    checkOutput("wr30_mem", {mem[8'h30], mem[8'h31]}, 16'h7856);
    checkOutput("wr30_rdata_kept", rdata, 16'h1234);

    // Back-to-back with req held high throughout.
    we = 1'b1; addr = 24'h000040; wdata = 16'hA55A; req = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 4; t++) begin
      cyc = 0;
      while (!done && cyc < 300) begin
        @(posedge clk); #1;
        cyc++;
      end
      checkOutput($sformatf("b2b%0d_latency", t), cyc, 96);
      if (t == 1) checkOutput("b2b_rd40", rdata, 16'hA55A);
      if (t == 3) checkOutput("b2b_rd42", rdata, 16'hC33C);
      case (t)
        0: begin we = 1'b0; addr = 24'h000040; end
        1: begin we = 1'b1; addr = 24'h000042; wdata = 16'hC33C; end
        2: begin we = 1'b0; addr = 24'h000042; end
        default: req = 1'b0;
      endcase
      @(posedge clk); #1;
      checkOutput($sformatf("b2b%0d_idle", t), {ready, spi_select}, 2'b11);
      if (t < 3) begin
        @(posedge clk); #1;
        checkOutput($sformatf("b2b%0d_accept", t), {ready, spi_select}, 2'b00);
      end
    end
    checkOutput("b2b_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h5AA5_3CC3);

    // Reset in the middle of a write.
    req = 1'b1; we = 1'b1; addr = 24'h000060; wdata = 16'h1111;
    @(posedge clk); #1;
    req = 1'b0;
    dcount = 0;
    repeat (39) begin
      if (done) dcount++;
      @(posedge clk); #1;
    end
    checkOutput("abort_busy", spi_select, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_pins", {spi_select, spi_clk, spi_mosi, done}, 4'b1000);
    checkOutput("abort_rdata", rdata, 16'h0000);
    rst_n = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    checkOutput("abort_no_done", dcount, 0);
    checkOutput("abort_mem", {mem[8'h60], mem[8'h61]}, 16'h0000);
    applyStimulus(1'b0, 24'h000010, 16'h0000, 1'b0, "rd_post");
    checkOutput("rd_post_rdata", rdata, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 2: bytes moved per transaction (legal 1..4); DW = 8*DATA_BYTES.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req  input  1  transaction request, sampled only while ready=1.
REQ-005 SHALL have port we  input  1  1=write (cmd 02h), 0=read (cmd 03h); sampled with req.
REQ-006 SHALL have port addr  input  24  byte address; sampled with req.
REQ-007 SHALL have port wdata  input  DW  write data; sampled with req.
REQ-008 SHALL have port ready  output  1  high exactly when idle and able to accept req.
REQ-009 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-010 SHALL have port rdata  output  DW  read data; valid from the done cycle until the next done.
REQ-011 SHALL have port spi_clk  output  1  SPI clock, mode 0, idle low.
REQ-012 SHALL have port spi_mosi  output  1  serial data to RAM.
REQ-013 SHALL have port spi_select  output  1  chip select, active-low.
REQ-014 SHALL have port spi_miso  input  1  serial data from RAM.

Function
REQ-015 SHALL implement states IDLE -> CMD -> DATA -> DONE -> IDLE; ready=1 only in IDLE.
REQ-016 SHALL accept on the rising edge where ready=1 and req=1 (cycle T), capturing we, addr, wdata into internal registers.
REQ-017 SHALL drive spi_select=0 from cycle T+1 through T+2*(32+8*DATA_BYTES), spi_select=1 otherwise.
REQ-018 SHALL run each SPI bit as two clk cycles: low phase (spi_clk=0, spi_mosi updated), then high phase (spi_clk=1, spi_mosi held).
REQ-019 SHALL in CMD shift 32 bits MSB-first: 8-bit command (03h/02h) then addr[23:0].
REQ-020 SHALL in DATA move bytes lowest first (byte k = bits 8k+7..8k), each byte MSB-first.
REQ-021 SHALL on write drive wdata bits on spi_mosi in DATA; on read drive spi_mosi=0 in DATA.
REQ-022 SHALL on read sample spi_miso at the end of each DATA high phase (clk edge lowering spi_clk) into the bit position per REQ-020.
REQ-023 SHALL ignore spi_miso during CMD and during write transactions; rdata unchanged by writes.
REQ-024 SHALL enter DONE the cycle after the last high phase: spi_select=1, spi_clk=0, done=1, rdata updated (reads); ready=1 on the following cycle.
REQ-025 SHALL give accept-to-done latency of 2*(32+8*DATA_BYTES)+1 cycles (97 for default).
REQ-026 SHALL ignore req while ready=0; a req held high through DONE is accepted in the next IDLE cycle (back-to-back gap: one cycle with spi_select=1 minimum).
REQ-027 SHALL drive spi_mosi=0 whenever spi_select=1.
REQ-028 SHALL keep a 6-bit bit counter; address has no wrap logic (RAM handles it).

Reset
REQ-029 SHALL on rst_n=0 at any clk edge, including mid-transaction, go to IDLE: spi_select=1, spi_clk=0, spi_mosi=0, done=0, ready=1 after release, rdata=0.
REQ-030 SHALL not emit done for a transaction aborted by reset.

Structure
REQ-031 SHALL place CMD_READ=8'h03, CMD_WRITE=8'h02 and the state enum in shared package spi_ram_pkg.
REQ-032 SHALL use sub-module spi_shift_reg (parallel-load, MSB-out/serial-in shift register) for command/data serialisation.

Verification (bench pairs block with the existing SPI RAM simulation model, DATA_BYTES=2)
REQ-033 Write we=1, addr=000010h, wdata=BEEFh -> MOSI bytes 02 00 00 10 EF BE; done at T+97; model byte 10h=EFh, 11h=BEh.
REQ-034 Read addr=000010h after REQ-033 -> MOSI 03 00 00 10 then zeros; done at T+97 with rdata=BEEFh.
REQ-035 Preload bytes 20h=34h, 21h=12h; read addr=000020h -> rdata=1234h (byte order check).
REQ-036 req held high continuously, alternating we/addr -> each accept exactly one cycle after preceding done; spi_select high one cycle between.
REQ-037 rst_n=0 at cycle T+40 of a write -> next cycle spi_select=1, spi_clk=0, no done; subsequent read works and returns expected data.
REQ-038 req toggled during busy -> no extra transaction, ready stays 0 until IDLE.
